oloca_arbiter: RTL and testbench

Shares one runtime-selectable approximate/exact 8-bit adder between NREQ requesters. Each requester issues operand pairs over a valid/ready handshake. A round-robin arbiter grants one requester per cycle into a 2-stage pipeline: capture, then compute. Results return on a single backpressured output tagged with the requester ID. The block sits between the approximate-adder datapath and client engines, and also keeps a saturating count of approximate operations for error-budget monitoring.

---
 rtl/oloca_pkg.sv | 11 +
 rtl/oloca_core.sv | 24 ++
 rtl/oloca_arbiter.sv | 129 ++++++++++++
 tb/tb_oloca_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oloca_pkg.sv
// Shared constants and mode encoding for the shared approximate/exact adder arbiter.
package oloca_pkg;
  localparam int OPW  = 8;
  localparam int RESW = 9;
  localparam int CNTW = 16;

  typedef enum logic {
    MODE_APPROX = 1'b0,
    MODE_EXACT  = 1'b1
  } mode_e;
endpackage

// File: rtl/oloca_core.sv
// Combinational 8-bit adder: exact ripple add, or OR-approximated low bits with
// an exact add of the upper bits (no carry crosses from the low part).
module oloca_core
  import oloca_pkg::*;
#(
  parameter int APPROX_BITS = 4
) (
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic            exact,
  output logic [RESW-1:0] sum
);
  localparam int LO  = APPROX_BITS;
  localparam int HIW = OPW - LO;

  logic [HIW:0]    hi_sum;
  logic [RESW-1:0] approx_sum;
  logic [RESW-1:0] exact_sum;

  assign hi_sum     = {1'b0, a[OPW-1:LO]} + {1'b0, b[OPW-1:LO]};
  assign approx_sum = {hi_sum, a[LO-1:0] | b[LO-1:0]};
  assign exact_sum  = {1'b0, a} + {1'b0, b};
  assign sum        = (mode_e'(exact) == MODE_EXACT) ? exact_sum : approx_sum;
endmodule

// File: rtl/oloca_arbiter.sv
// Round-robin arbiter feeding a two-stage (capture, compute) shared adder pipeline
// with a backpressured tagged result port and a saturating approximate-op counter.
module oloca_arbiter
  import oloca_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int APPROX_BITS = 4,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]     req_exact,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RESW-1:0]     res_sum,
  output logic [IDW-1:0]      res_id,
  output logic                res_exact,
  output logic [CNTW-1:0]     approx_cnt,
  input  logic                cnt_clr
);
  logic            s1_valid_reg;
  logic [OPW-1:0]  s1_a_reg;
  logic [OPW-1:0]  s1_b_reg;
  logic            s1_exact_reg;
  logic [IDW-1:0]  s1_id_reg;
  logic            res_valid_reg;
  logic [RESW-1:0] res_sum_reg;
  logic [IDW-1:0]  res_id_reg;
  logic            res_exact_reg;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [CNTW-1:0] approx_cnt_reg;

  logic            s2_adv;
  logic            s1_free;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic            grant_en;
  logic [RESW-1:0] core_sum;

  logic [OPW-1:0]  a_arr [NREQ];
  logic [OPW-1:0]  b_arr [NREQ];

  assign s2_adv  = s1_valid_reg & (~res_valid_reg | res_ready);
  assign s1_free = ~s1_valid_reg | s2_adv;

  // Search upward from rr_ptr, wrapping at NREQ; the first valid requester wins.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  // No grants are offered while the block is held in reset.
  assign grant_en = s1_free & grant_any & rst_n;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_ready[gi] = grant_en & (grant_idx == IDW'(gi));
    assign a_arr[gi]     = req_a[8*gi +: 8];
    assign b_arr[gi]     = req_b[8*gi +: 8];
  end

  oloca_core #(
    .APPROX_BITS (APPROX_BITS)
  ) u_core (
    .a     (s1_a_reg),
    .b     (s1_b_reg),
    .exact (s1_exact_reg),
    .sum   (core_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_a_reg       <= '0;
      s1_b_reg       <= '0;
      s1_exact_reg   <= 1'b0;
      s1_id_reg      <= '0;
      res_valid_reg  <= 1'b0;
      res_sum_reg    <= '0;
      res_id_reg     <= '0;
      res_exact_reg  <= 1'b0;
      rr_ptr_reg     <= '0;
      approx_cnt_reg <= '0;
    end else begin
      if (s1_free) begin
        s1_valid_reg <= grant_en;
        if (grant_en) begin
          s1_a_reg     <= a_arr[grant_idx];
          s1_b_reg     <= b_arr[grant_idx];
          s1_exact_reg <= req_exact[grant_idx];
          s1_id_reg    <= grant_idx;
          rr_ptr_reg   <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
      end

      if (s2_adv) begin
        res_valid_reg <= 1'b1;
        res_sum_reg   <= core_sum;
        res_id_reg    <= s1_id_reg;
        res_exact_reg <= s1_exact_reg;
      end else if (res_ready) begin
        res_valid_reg <= 1'b0;
      end

      if (cnt_clr) begin
        approx_cnt_reg <= '0;
      end else if (res_valid_reg && res_ready && !res_exact_reg && approx_cnt_reg != '1) begin
        approx_cnt_reg <= approx_cnt_reg + 1'b1;
      end
    end
  end

  assign res_valid  = res_valid_reg;
  assign res_sum    = res_sum_reg;
  assign res_id     = res_id_reg;
  assign res_exact  = res_exact_reg;
  assign approx_cnt = approx_cnt_reg;
endmodule

// File: tb/tb_oloca_arbiter.sv
// Randomized bench for oloca_arbiter against a transaction-level model:
// grants from a round-robin pointer, results from an in-order queue with 2-cycle latency.
module tb_oloca_arbiter;
  localparam int NREQ = 4;
  localparam int AB   = 4;
  localparam int IDW  = $clog2(NREQ);

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_a;
  logic [8*NREQ-1:0]   req_b;
  logic [NREQ-1:0]     req_exact;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic                res_ready;
  logic [8:0]          res_sum;
  logic [IDW-1:0]      res_id;
  logic                res_exact;
  logic [15:0]         approx_cnt;
  logic                cnt_clr;

  oloca_arbiter #(.NREQ(NREQ), .APPROX_BITS(AB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_exact  (req_exact),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_id     (res_id),
    .res_exact  (res_exact),
    .approx_cnt (approx_cnt),
    .cnt_clr    (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] sum;
    int         id;
    logic       exact;
    int         gcyc;
  } item_t;

  item_t       q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rr = 0;
  logic [15:0] m_cnt = 16'h0;

  logic [NREQ-1:0] pend;
  logic [7:0]      pa [NREQ];
  logic [7:0]      pb [NREQ];
  logic            pe [NREQ];
  int              p_new, p_ready, p_clr, p_exact;

  logic            got;
  logic [8:0]      last_sum;
  int              last_id;
  int              last_pop_cyc, last_grant_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b, input logic e);
    int mask, hi, lo;
    if (e) return 9'(int'(a) + int'(b));
    mask = (1 << AB) - 1;
    hi   = ((int'(a) >> AB) + (int'(b) >> AB)) << AB;
    lo   = (int'(a) | int'(b)) & mask;
    return 9'(hi | lo);
  endfunction

  task automatic drive_vectors();
    req_valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = pa[i];
      req_b[8*i +: 8] = pb[i];
      req_exact[i]    = pe[i];
    end
  endtask

  // One clock: drive at negedge, compare at negedge+1, then advance the model.
  task automatic step();
    logic head_vis, can_acc;
    int   g, idx;
    logic [NREQ-1:0] exp_ready;
    item_t it;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && $urandom_range(99) < p_new) begin
        pend[i] = 1'b1;
        pa[i]   = 8'($urandom);
        pb[i]   = 8'($urandom);
        pe[i]   = ($urandom_range(99) < p_exact);
      end
    end
    res_ready = ($urandom_range(99) < p_ready);
    cnt_clr   = ($urandom_range(99) < p_clr);
    drive_vectors();
    #1;
    head_vis = (q.size() > 0) && (q[0].gcyc + 2 <= cyc);
    check("res_valid", 32'(res_valid), 32'(head_vis));
    if (head_vis) begin
      check("res_sum", 32'(res_sum), 32'(q[0].sum));
      check("res_id", 32'(res_id), 32'(q[0].id));
      check("res_exact", 32'(res_exact), 32'(q[0].exact));
    end
    can_acc = (q.size() < 2) || res_ready;
    g = -1;
    if (can_acc) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr + k) % NREQ;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("approx_cnt", 32'(approx_cnt), 32'(m_cnt));

    if (head_vis && res_ready) begin
      it = q.pop_front();
      $display("res id=%0d sum=%03h exact=%0d cycle=%0d", it.id, res_sum, it.exact, cyc);
      got = 1'b1;
      last_sum = res_sum;
      last_id = int'(res_id);
      last_pop_cyc = cyc;
      if (!it.exact && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
    end
    if (cnt_clr) m_cnt = 16'h0;
    if (g >= 0) begin
      it.sum = ref_sum(pa[g], pb[g], pe[g]);
      it.id = g;
      it.exact = pe[g];
      it.gcyc = cyc;
      q.push_back(it);
      pend[g] = 1'b0;
      rr = (g + 1) % NREQ;
      last_grant_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic wait_result(input string tag, input logic [8:0] es, input int eid);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) step();
    check({tag, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_sum"}, 32'(last_sum), 32'(es));
      check({tag, "_id"}, 32'(last_id), 32'(eid));
      check({tag, "_lat"}, 32'(last_pop_cyc - last_grant_cyc), 32'd2);
    end
  endtask

  task automatic directed(input int r, input logic [7:0] a, input logic [7:0] b, input logic e);
    pend[r] = 1'b1;
    pa[r] = a;
    pb[r] = b;
    pe[r] = e;
  endtask

  initial begin
    logic [8:0] held_sum;
    logic [IDW-1:0] held_id;
    rst_n = 1'b0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = 8'h0; pb[i] = 8'h0; pe[i] = 1'b0;
    end
    drive_vectors();
    req_valid = '1;
    res_ready = 1'b1;
    cnt_clr = 1'b0;
    p_new = 0; p_ready = 100; p_clr = 0; p_exact = 50;

    // Reset values, with requests asserted to show no grant leaks out during reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_exact", 32'(res_exact), 32'd0);
    check("rst_approx_cnt", 32'(approx_cnt), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed operand cases.
    directed(0, 8'h0F, 8'h01, 1'b0); wait_result("t0_apx", 9'h00F, 0);
    directed(0, 8'h0F, 8'h01, 1'b1); wait_result("t0_ext", 9'h010, 0);
    directed(2, 8'hFF, 8'hFF, 1'b0); wait_result("t2_apx", 9'h1EF, 2);
    directed(2, 8'hFF, 8'hFF, 1'b1); wait_result("t2_ext", 9'h1FE, 2);

    // Fairness: everyone always valid, consumer always ready.
    p_new = 100; p_ready = 100;
    repeat (24) step();

    // Backpressure: stall, confirm the output holds, then drain.
    p_ready = 0;
    repeat (3) step();
    held_sum = res_sum;
    held_id = res_id;
    repeat (2) step();
    check("stall_sum_hold", 32'(res_sum), 32'(held_sum));
    check("stall_id_hold", 32'(res_id), 32'(held_id));
    check("stall_full_ready", 32'(req_ready), 32'd0);
    p_ready = 100;
    repeat (6) step();

    // Random mix.
    p_new = 60; p_ready = 70; p_clr = 2; p_exact = 50;
    repeat (400) step();

    // Counter saturation: quiesce, preload near the top, then push approximate results.
    p_new = 0; p_ready = 100; p_clr = 0;
    pend = '0;
    repeat (6) step();
    check("cnt_idle_empty", 32'(q.size()), 32'd0);
    force dut.approx_cnt_reg = 16'hFFFD;
    @(posedge clk);
    #1 release dut.approx_cnt_reg;
    m_cnt = 16'hFFFD;
    p_new = 100; p_exact = 0;
    repeat (8) step();
    check("cnt_saturated", 32'(approx_cnt), 32'hFFFF);
    p_clr = 100;
    step();
    p_clr = 0;
    @(posedge clk);
    #1 check("cnt_clr_prio", 32'(approx_cnt), 32'd0);
    p_exact = 50;
    repeat (10) step();

    // Reset with both stages full.
    p_new = 100; p_ready = 0;
    repeat (4) step();
    check("pre_rst_full", 32'(q.size()), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    q.delete();
    rr = 0;
    m_cnt = 16'h0;
    pend = '0;
    drive_vectors();
    @(posedge clk);
    #2 rst_n = 1'b1;
    p_new = 0; p_ready = 100;
    directed(1, 8'h33, 8'h44, 1'b1);
    wait_result("post_rst", 9'h077, 1);

    p_new = 50; p_ready = 80; p_clr = 1;
    repeat (200) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
